// File: rtl/hex_stream_formatter.sv
// ASCII-hex serialiser: buffers WIDTH-bit values in a small FIFO and streams each
// one out as hex characters with an optional "0x" prefix and terminator byte.
module hex_stream_formatter #(
  parameter int          WIDTH     = 32,
  parameter int          DEPTH     = 4,
  parameter bit          UPPERCASE = 1'b0,
  parameter bit          PREFIX    = 1'b0,
  parameter bit          TERM_EN   = 1'b1,
  parameter logic [7:0]  TERM      = 8'h0A
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_ready,
  input  logic                     suppress,
  input  logic                     output_busy,
  output logic                     output_en,
  output logic [7:0]               output_data,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     idle
);

  localparam int NDIG = (WIDTH + 3) / 4;
  localparam int SW   = NDIG * 4;
  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int NW   = $clog2(NDIG + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_PFX0, S_PFX1, S_DIGITS, S_TERM
  } state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   mem [DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count;
  logic [SW-1:0]      sreg;
  logic [NW-1:0]      ndig;
  logic [NW-1:0]      lz;
  logic               sup;
  logic               push, pop, byte_pending, found;
  logic [3:0]         nib;
  logic [7:0]         digit_byte, byte_out;

  assign in_ready   = (count != CW'(DEPTH));
  assign push       = in_valid & in_ready;
  assign pop        = (state == S_IDLE) && (count != '0);
  assign fifo_count = count;
  assign idle       = (state == S_IDLE) && (count == '0);

  // NOTE: the storage array carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Leading-zero nibble count; the last nibble is never skipped so zero prints "0".
  always_comb begin
    lz    = '0;
    found = 1'b0;
    for (int i = 0; i < NDIG - 1; i++) begin
      if (!found) begin
        if (sreg[SW-1-4*i -: 4] == 4'h0) lz = lz + 1'b1;
        else                             found = 1'b1;
      end
    end
    if (!sup) lz = '0;
  end

  assign nib        = sreg[SW-1 -: 4];
  assign digit_byte = (nib < 4'd10) ? 8'h30 + {4'h0, nib}
                                    : (UPPERCASE ? 8'h41 : 8'h61) + {4'h0, nib} - 8'd10;

  // NOTE: every output of this block gets a default first, so no latches are inferred.
  always_comb begin
    state_next   = state;
    byte_pending = 1'b0;
    byte_out     = 8'h00;
    case (state)
      S_IDLE:   if (pop) state_next = S_LOAD;
      S_LOAD:   state_next = PREFIX ? S_PFX0 : S_DIGITS;
      S_PFX0: begin
        byte_pending = 1'b1;
        byte_out     = 8'h30;
        if (!output_busy) state_next = S_PFX1;
      end
      S_PFX1: begin
        byte_pending = 1'b1;
        byte_out     = 8'h78;
        if (!output_busy) state_next = S_DIGITS;
      end
      S_DIGITS: begin
        byte_pending = 1'b1;
        byte_out     = digit_byte;
        if (!output_busy && ndig == NW'(1)) state_next = TERM_EN ? S_TERM : S_IDLE;
      end
      S_TERM: begin
        byte_pending = 1'b1;
        byte_out     = TERM;
        if (!output_busy) state_next = S_IDLE;
      end
      default:  state_next = S_IDLE;
    endcase
  end

  assign output_en   = byte_pending & ~output_busy;
  assign output_data = byte_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      sreg  <= '0;
      ndig  <= '0;
      sup   <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: if (pop) begin
          sreg <= SW'(mem[rd_ptr]);
          sup  <= suppress;
        end
        S_LOAD: begin
          sreg <= sreg << {lz, 2'b00};
          ndig <= NW'(NDIG) - lz;
        end
        S_DIGITS: if (!output_busy) begin
          sreg <= sreg << 4;
          ndig <= ndig - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hex_stream_formatter.sv
// Directed bench for hex_stream_formatter: three parameterisations share clock,
// reset, busy and suppress; emitted bytes are collected and compared to strings.
module tb_hex_stream_formatter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_valid2, suppress, busy;
  logic [31:0] in_data;
  logic [9:0]  in_data2;
  logic        rdy0, rdy1, rdy2, en0, en1, en2, idle0, idle1, idle2;
  logic [7:0]  d0, d1, d2;
  logic [2:0]  cnt0, cnt1, cnt2;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int viol   = 0;
  int push_cyc;
  logic [7:0] q0[$], q1[$], q2[$];
  int         qc0[$];

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  hex_stream_formatter dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy0),
    .suppress(suppress), .output_busy(busy), .output_en(en0), .output_data(d0),
    .fifo_count(cnt0), .idle(idle0));

  hex_stream_formatter #(.UPPERCASE(1'b1), .PREFIX(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy1),
    .suppress(suppress), .output_busy(busy), .output_en(en1), .output_data(d1),
    .fifo_count(cnt1), .idle(idle1));

  hex_stream_formatter #(.WIDTH(10)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_data(in_data2), .in_ready(rdy2),
    .suppress(suppress), .output_busy(busy), .output_en(en2), .output_data(d2),
    .fifo_count(cnt2), .idle(idle2));

  always @(negedge clk) begin
    if (en0) begin q0.push_back(d0); qc0.push_back(cycle); end
    if (en1) q1.push_back(d1);
    if (en2) q2.push_back(d2);
    if ((en0 || en1 || en2) && busy) viol++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_bytes(input string tag, input int which, input string s);
    logic [7:0] got[$];
    case (which)
      0:       begin got = q0; q0.delete(); qc0.delete(); end
      1:       begin got = q1; q1.delete(); end
      default: begin got = q2; q2.delete(); end
    endcase
    check({tag, " len"}, 64'(got.size()), 64'(s.len()));
    for (int i = 0; i < s.len() && i < got.size(); i++)
      check($sformatf("%s byte%0d", tag, i), 64'(got[i]), 64'(s[i]));
  endtask

  task automatic push(input logic [31:0] v);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = v;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rdy0) begin
        @(posedge clk); #1;
        push_cyc = cycle;
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    if (!ok) check("push timeout", 64'(ok), 64'd1);
  endtask

  task automatic push2(input logic [9:0] v);
    bit ok = 1'b0;
    in_valid2 = 1'b1;
    in_data2  = v;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rdy2) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
    end
    in_valid2 = 1'b0;
    if (!ok) check("push2 timeout", 64'(ok), 64'd1);
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (idle0 && idle1 && idle2) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    check({tag, " idle"}, 64'(ok), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0; in_data = '0; in_data2 = '0;
    suppress = 1'b0; busy = 1'b0;
    #12;
    check("rst in_ready",  64'(rdy0),  64'd1);
    check("rst output_en", 64'(en0),   64'd0);
    check("rst data",      64'(d0),    64'h00);
    check("rst count",     64'(cnt0),  64'd0);
    check("rst idle",      64'(idle0), 64'd1);
    check("rst idle w10",  64'(idle2), 64'd1);
    #10 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 1: basic value, latency and consecutive bytes
    push(32'hDEAD1234);
    wait_idle("t1");
    check("t1 latency", 64'(qc0.size() > 0 ? qc0[0] - push_cyc : -1), 64'd2);
    for (int i = 1; i < 9 && i < qc0.size(); i++)
      check($sformatf("t1 consecutive %0d", i), 64'(qc0[i] - qc0[0]), 64'(i));
    expect_bytes("t1", 0, "dead1234\n");
    expect_bytes("t1 pfx", 1, "0xDEAD1234\n");

    // 2: leading-zero suppression, including a zero value
    suppress = 1'b1;
    push(32'h0000_00A0);
    push(32'h0);
    wait_idle("t2");
    expect_bytes("t2", 0, "a0\n0\n");
    expect_bytes("t2 pfx", 1, "0xA0\n0x0\n");

    // 3: 10-bit width, padded top digit
    suppress = 1'b0;
    push2(10'h3FF);
    wait_idle("t3");
    expect_bytes("t3", 2, "3ff\n");
    suppress = 1'b1;
    push2(10'h005);
    wait_idle("t3s");
    expect_bytes("t3s", 2, "5\n");

    // 4: fill FIFO under busy, overflow offer must be held
    busy = 1'b1;
    for (int v = 1; v <= 5; v++) push(32'(v));
    check("t4 count full",  64'(cnt0), 64'd4);
    check("t4 ready low",   64'(rdy0), 64'd0);
    in_valid = 1'b1; in_data = 32'h6;
    repeat (3) begin @(posedge clk); #1; end
    check("t4 count held",  64'(cnt0), 64'd4);
    check("t4 ready held",  64'(rdy0), 64'd0);
    in_valid = 1'b0;
    check("t4 no bytes",    64'(q0.size()), 64'd0);
    busy = 1'b0;
    wait_idle("t4");
    expect_bytes("t4", 0, "1\n2\n3\n4\n5\n");
    expect_bytes("t4 pfx", 1, "0x1\n0x2\n0x3\n0x4\n0x5\n");

    // 5: random busy gives identical stream, never emitting while busy
    suppress = 1'b0;
    viol = 0;
    push(32'hDEAD1234);
    begin
      bit ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
        busy = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        if (idle0 && idle1) begin ok = 1'b1; break; end
      end
      busy = 1'b0;
      check("t5 done", 64'(ok), 64'd1);
    end
    check("t5 emit while busy", 64'(viol), 64'd0);
    expect_bytes("t5", 0, "dead1234\n");
    expect_bytes("t5 pfx", 1, "0xDEAD1234\n");

    // 6: reset mid-value drops everything at once
    push(32'hDEAD1234);
    push(32'h5555_5555);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (q0.size() >= 3) break;
    end
    check("t6 3 bytes", 64'(q0.size()), 64'd3);
    check("t6 count before", 64'(cnt0), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("t6 output_en", 64'(en0),  64'd0);
    check("t6 count",     64'(cnt0), 64'd0);
    check("t6 data",      64'(d0),   64'h00);
    check("t6 idle",      64'(idle0), 64'd1);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    q0.delete(); qc0.delete(); q1.delete();
    @(posedge clk); #1;
    push(32'h0000_0012);
    wait_idle("t6");
    expect_bytes("t6", 0, "00000012\n");
    expect_bytes("t6 pfx", 1, "0x00000012\n");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
